key_event_scan: RTL

- Parametrised successor to the fixed four-key checker; handles NUM_KEYS active-low front-panel keys.
- Each key input is synchronised and debounced.
- Each key produces press, release, long-press and auto-repeat events.
- Events are queued in a show-ahead FIFO, which dsp_com drains over the DSP bus.

---
 rtl/key_event_scan.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/key_event_scan.sv
// ---------------------------------------------------------------------------
// key_event_scan
//
// Front-panel key scanner for NUM_KEYS active-low keys. Each key pin is
// synchronised, debounced and fed to a small per-key state machine that
// produces PRESS, RELEASE, LONG and (optionally) REPEAT events. Each key owns
// one pending slot. A fixed-priority arbiter moves one slot per cycle into a
// show-ahead FIFO, which dsp_com drains over the DSP bus.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   : while a key stays in LONG_HELD, a REPEAT event is raised
//               every REPEAT_CYC cycles until the key is released.
//   undefined : no REPEAT events (type 2'b11 never appears), and the
//               LONG_HELD hold counter is not built.
//
// Ports
//   clk_in     in   1        system clock
//   sys_rst    in   1        synchronous active-high reset
//   key_in     in   NUM_KEYS raw key pins, 0 = pressed
//   key_state  out  NUM_KEYS debounced level, 1 = pressed
//   evt_valid  out  1        FIFO not empty
//   evt_data   out  8        FIFO head {type[1:0], key index[5:0]}, 0 when empty
//   evt_rd     in   1        pop the head entry
//   evt_count  out  CNT_W    entries currently stored
//   overflow   out  1        sticky: an event was lost
//   ovf_clr    in   1        clears overflow
// ---------------------------------------------------------------------------
module key_event_scan #(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CYC = 600000,
  parameter int LONG_CYC     = 30000000,
  parameter int REPEAT_CYC   = 6000000,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            clk_in,
  input  logic                            sys_rst,
  input  logic [NUM_KEYS-1:0]             key_in,
  output logic [NUM_KEYS-1:0]             key_state,
  output logic                            evt_valid,
  output logic [7:0]                      evt_data,
  input  logic                            evt_rd,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] evt_count,
  output logic                            overflow,
  input  logic                            ovf_clr
);

  localparam int DB_BITS  = $clog2(DEBOUNCE_CYC);
  localparam int DB_W     = (DB_BITS > 20) ? DB_BITS : 20;
  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HOLD_W   = ($clog2(HOLD_MAX) > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);
`endif
  localparam logic [CNT_W-1:0]  FIFO_FULL_COUNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
`ifdef KEY_REPEAT_EN
  localparam logic [1:0] EVT_REPEAT  = 2'b11;
`endif

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_HELD = 2'd2
  } keyFsm_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_syncPressed;
  logic [NUM_KEYS-1:0] r_keyState;
  logic [DB_W-1:0]     r_dbCnt [NUM_KEYS];

  keyFsm_t             r_fsm      [NUM_KEYS];
  keyFsm_t             w_fsmNext  [NUM_KEYS];
  logic [HOLD_W-1:0]   r_hold     [NUM_KEYS];
  logic [HOLD_W-1:0]   w_holdNext [NUM_KEYS];
  logic [NUM_KEYS-1:0] w_raise;
  logic [1:0]          w_raiseType [NUM_KEYS];

  logic [NUM_KEYS-1:0] r_pendValid;
  logic [1:0]          r_pendType [NUM_KEYS];

  logic                w_grantValid;
  logic [5:0]          w_grantIdx;
  logic [1:0]          w_grantType;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [CNT_W-1:0]    r_count;
  logic                w_fifoFull;
  logic                w_pop;
  logic                w_push;
  logic                w_ovfSet;
  logic                r_overflow;

  // Two-flop synchroniser on the raw pins. Reset presets both stages to the
  // released level so no phantom press appears when reset is released.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Keys are active-low on the pins; everything past the synchroniser
  // works with 1 = pressed.
  assign w_syncPressed = ~r_sync2;

  // Debounce: a key only changes its accepted level once the synchronised
  // level has disagreed with it for DEBOUNCE_CYC consecutive cycles. Any
  // cycle of agreement restarts the count, so short glitches are ignored.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      r_keyState <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_dbCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_syncPressed[i] == r_keyState[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == DB_LAST) begin
          r_keyState[i] <= ~r_keyState[i];
          r_dbCnt[i]    <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Per-key state register and hold counter.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_fsm[i]  <= ST_IDLE;
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_fsm[i]  <= w_fsmNext[i];
        r_hold[i] <= w_holdNext[i];
      end
    end
  end

  // Per-key next state and event raising. The FSM reacts to the debounced
  // level, so a level change is seen exactly once, in the cycle after
  // key_state moves. Release always takes priority over a LONG or REPEAT
  // event that would fall due in the same cycle.
  always_comb begin
    w_raise = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_fsmNext[i]   = r_fsm[i];
      w_holdNext[i]  = r_hold[i];
      w_raiseType[i] = EVT_PRESS;
      case (r_fsm[i])
        ST_IDLE: begin
          if (r_keyState[i]) begin
            w_raise[i]     = 1'b1;
            w_raiseType[i] = EVT_PRESS;
            w_holdNext[i]  = '0;
            w_fsmNext[i]   = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!r_keyState[i]) begin
            w_raise[i]     = 1'b1;
            w_raiseType[i] = EVT_RELEASE;
            w_holdNext[i]  = '0;
            w_fsmNext[i]   = ST_IDLE;
          end else if (r_hold[i] == LONG_LAST) begin
            w_raise[i]     = 1'b1;
            w_raiseType[i] = EVT_LONG;
            w_holdNext[i]  = '0;
            w_fsmNext[i]   = ST_LONG_HELD;
          end else begin
            w_holdNext[i] = r_hold[i] + HOLD_W'(1);
          end
        end
        ST_LONG_HELD: begin
          if (!r_keyState[i]) begin
            w_raise[i]     = 1'b1;
            w_raiseType[i] = EVT_RELEASE;
            w_holdNext[i]  = '0;
            w_fsmNext[i]   = ST_IDLE;
          end
`ifdef KEY_REPEAT_EN
          else if (r_hold[i] == REPEAT_LAST) begin
            w_raise[i]     = 1'b1;
            w_raiseType[i] = EVT_REPEAT;
            w_holdNext[i]  = '0;
          end else begin
            w_holdNext[i] = r_hold[i] + HOLD_W'(1);
          end
`endif
        end
        default: begin
          w_holdNext[i] = '0;
          w_fsmNext[i]  = ST_IDLE;
        end
      endcase
    end
  end

  // Fixed-priority arbiter: the lowest-index valid pending slot wins.
  // Scanning downwards lets the lowest index overwrite any higher one.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_grantType  = EVT_PRESS;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (r_pendValid[i]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = 6'(i);
        w_grantType  = r_pendType[i];
      end
    end
  end

  // A pop frees a place in the same cycle, so a full FIFO still accepts a
  // write when it is being read at the same time.
  assign w_pop      = evt_rd && (r_count != '0);
  assign w_fifoFull = (r_count == FIFO_FULL_COUNT);
  assign w_push     = w_grantValid && (!w_fifoFull || w_pop);

  // An event is lost when it lands on a slot that is still waiting and is
  // not being granted this cycle, or when a granted entry finds the FIFO
  // full. A slot that is granted and re-raised in one cycle loses nothing.
  always_comb begin
    w_ovfSet = w_grantValid && !w_push;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_raise[i] && r_pendValid[i] &&
          !(w_grantValid && (w_grantIdx == 6'(i)))) begin
        w_ovfSet = 1'b1;
      end
    end
  end

  // Pending slots: a new event always takes the slot, otherwise a grant
  // empties it. A dropped FIFO write still empties the slot.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      r_pendValid <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_pendType[i] <= EVT_PRESS;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (w_raise[i]) begin
          r_pendValid[i] <= 1'b1;
          r_pendType[i]  <= w_raiseType[i];
        end else if (w_grantValid && (w_grantIdx == 6'(i))) begin
          r_pendValid[i] <= 1'b0;
        end
      end
    end
  end

  // Event FIFO storage and pointers. Pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= {w_grantType, w_grantIdx};
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Sticky overflow flag. A new loss in the same cycle as a clear keeps
  // the flag set so the loss is never hidden.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovfSet) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign key_state = r_keyState;
  assign evt_valid = (r_count != '0);
  assign evt_data  = evt_valid ? r_mem[r_rdPtr] : 8'h00;
  assign evt_count = r_count;
  assign overflow  = r_overflow;

endmodule
